image_loader: RTL and testbench
===============================

// Module: image_loader
// PURPOSE
//   Front-end writer for the MNIST inference engine. Receives one image as a
//   valid/ready pixel stream and writes it into the image RAM that the
//   network reads.
//   Then pulses the network start, waits for its done, and returns the
//   predicted class over a valid/ready result handshake.
//   Sits between the host/stream source and the inference top level.
// PARAMETERS
//   NUM_PIXELS      784     pixels per frame (28x28)
//   ADDR_W          10      image RAM address width
//   DATA_W          16      pixel width (Q-format, passed through untouched)
//   TIMEOUT_CYCLES  200000  max cycles in WAIT before declaring an error
// PORTS
//   clk             in   1       clock
//   rst             in   1       reset, asynchronous, active-high
//   pix_data        in   DATA_W  pixel value
//   pix_valid       in   1       pixel beat valid
//   pix_last        in   1       marks final beat of a frame
//   pix_ready       out  1       loader accepts a beat
//   mem_we          out  1       image RAM write enable
//   mem_addr        out  ADDR_W  image RAM write address
//   mem_wdata       out  DATA_W  image RAM write data
//   net_start       out  1       one-cycle start pulse to network
//   net_done        in   1       network result ready (single-cycle pulse)
//   net_prediction  in   16      network class index, sampled on net_done
//   res_valid       out  1       result available
//   res_ready       in   1       consumer accepts result
//   res_class       out  16      predicted class; 16'hFFFF on error
//   res_error       out  1       frame-length error or network timeout
//   busy            out  1       high in any state other than LOAD with count==0
// BEHAVIOUR
//   Reset: state=LOAD, pixel count=0, timeout count=0.
//     All outputs 0 except pix_ready=1.
//   States: LOAD -> {START | DRAIN | RESULT}, DRAIN -> RESULT,
//     START -> WAIT, WAIT -> RESULT, RESULT -> LOAD.
//   LOAD: pix_ready=1. Transfer = pix_valid & pix_ready.
//     A transfer in cycle N gives mem_we=1, mem_addr=count,
//     mem_wdata=pix_data in cycle N+1 (registered, 1-cycle latency).
//     count increments. No transfer -> mem_we=0 next cycle.
//   - pix_last with count==NUM_PIXELS-1: write it, go START.
//   - pix_last with count<NUM_PIXELS-1 (short frame): write it, go RESULT.
//     res_error=1, res_class=16'hFFFF, no net_start.
//   - count==NUM_PIXELS-1 without pix_last (long frame): write it, go DRAIN.
//   DRAIN: pix_ready=1, beats discarded (mem_we=0).
//     Transfer with pix_last -> RESULT, res_error=1, res_class=16'hFFFF.
//   START: pix_ready=0. net_start=1 for exactly one cycle, the cycle after
//     the final mem_we (last write is committed first). Next state is WAIT.
//   WAIT: pix_ready=0, timeout count increments each cycle.
//   - net_done=1: res_class<=net_prediction, res_error<=0, go RESULT.
//   - timeout count reaches TIMEOUT_CYCLES-1 with no net_done:
//     res_error<=1, res_class<=16'hFFFF, go RESULT.
//   - net_done and timeout in the same cycle: net_done wins.
//   net_done in any state other than WAIT is ignored.
//   RESULT: res_valid=1. res_class and res_error stay stable until
//     res_valid & res_ready. In the cycle after the handshake:
//     res_valid=0, state=LOAD, count=0, timeout=0.
//     pix_ready=0 throughout RESULT (back-pressure until result taken).
//   count is ADDR_W bits and never wraps; it is clamped by the rules above.
//   Reset mid-frame or mid-WAIT: immediate async return to reset values.
//     Partial RAM contents are not cleared. The network shares rst.
// TESTING
//   1. 784 beats (pix_data=addr, last on beat 783), res_ready=1, net_done
//      after 50 cycles with prediction=7 -> 784 writes at addr 0..783 data
//      0..783; one net_start one cycle after write 783; res_class=7,
//      res_error=0.
//   2. Random pix_valid gaps (50% duty) -> identical write sequence and
//      exactly one net_start.
//   3. pix_last on beat 99 -> 100 writes, no net_start, res_error=1,
//      res_class=16'hFFFF.
//   4. 790 beats, last on beat 789 -> exactly 784 writes, beats 784..789
//      dropped, res_error=1, no net_start.
//   5. net_done never asserted, TIMEOUT_CYCLES=100 -> res_valid 100 cycles
//      after net_start, res_error=1. Hold res_ready=0 for 20 cycles: result
//      stable and pix_ready=0 throughout.
//   6. Assert rst at beat 400 of a frame -> all outputs 0 and pix_ready=1
//      asynchronously. A following full frame completes as in test 1.

Source files
------------

// File: rtl/image_loader.sv
// image_loader
//   Front-end writer for the MNIST inference engine. Accepts one frame of
//   pixels on a valid/ready stream, writes them into the image RAM, pulses
//   the network start, waits for the network's done pulse (with a cycle
//   timeout) and hands the predicted class back on a valid/ready result
//   interface.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   pix_data/valid/last, pix_ready   pixel stream input
//   mem_we/addr/wdata                image RAM write port (1-cycle latency)
//   net_start, net_done, net_prediction   network control
//   res_valid/ready, res_class, res_error  result output (class 16'hFFFF on error)
//   busy            high unless idle in LOAD with no pixels taken yet
module image_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              net_start,
    input  logic              net_done,
    input  logic [15:0]       net_prediction,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_class,
    output logic              res_error,
    output logic              busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]       ERR_CLASS = 16'hFFFF;

    typedef enum logic [2:0] {
        S_LOAD,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] count;
    logic [TO_W-1:0]   timeout;
    logic              accepting;
    logic              xfer;
    logic              at_last;
    logic              timed_out;

    assign accepting = (state == S_LOAD) || (state == S_DRAIN);
    assign pix_ready = accepting;
    assign xfer      = pix_valid & accepting;
    assign at_last   = (count == LAST_IDX);
    assign timed_out = (timeout == TO_LAST);
    assign busy      = !((state == S_LOAD) && (count == '0));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        res_valid = 1'b0;
        case (state)
            S_LOAD: begin
                if (xfer) begin
                    if (at_last) begin
                        state_nxt = pix_last ? S_START : S_DRAIN;
                    end else if (pix_last) begin
                        state_nxt = S_RESULT;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && pix_last) begin
                    state_nxt = S_RESULT;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (net_done || timed_out) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Datapath: RAM write port, counters, start pulse, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            net_start <= 1'b0;
            count     <= '0;
            timeout   <= '0;
            res_class <= '0;
            res_error <= 1'b0;
        end else begin
            mem_we <= (state == S_LOAD) && xfer;
            // Registered from START so the pulse lands one cycle after the
            // final RAM write, which is itself registered.
            net_start <= (state == S_START);

            case (state)
                S_LOAD: begin
                    if (xfer) begin
                        mem_addr  <= count;
                        mem_wdata <= pix_data;
                        count     <= count + ADDR_W'(1);
                        if (pix_last && !at_last) begin
                            res_error <= 1'b1;
                            res_class <= ERR_CLASS;
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer && pix_last) begin
                        res_error <= 1'b1;
                        res_class <= ERR_CLASS;
                    end
                end
                S_WAIT: begin
                    timeout <= timeout + TO_W'(1);
                    if (net_done) begin
                        res_class <= net_prediction;
                        res_error <= 1'b0;
                    end else if (timed_out) begin
                        res_class <= ERR_CLASS;
                        res_error <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        count   <= '0;
                        timeout <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader
//   Self-checking bench for image_loader. Frame scenarios are listed in a
//   table of records; expected RAM writes are queued as beats are accepted
//   and popped as the DUT writes. Reset behaviour is a hand-written sequence.
module tb_image_loader;

    localparam int NPIX = 784;
    localparam int TO   = 100;

    logic        clk;
    logic        rst;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        net_start;
    logic        net_done;
    logic [15:0] net_prediction;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_class;
    logic        res_error;
    logic        busy;

    image_loader #(
        .NUM_PIXELS    (NPIX),
        .ADDR_W        (10),
        .DATA_W        (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_last      (pix_last),
        .pix_ready     (pix_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .net_start     (net_start),
        .net_done      (net_done),
        .net_prediction(net_prediction),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_class     (res_class),
        .res_error     (res_error),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          nbeats;
        int          last_idx;
        bit          gaps;
        int          done_delay;   // cycles after net_start; -1 = never
        logic [15:0] pred;
        int          hold;         // cycles to hold res_ready low
        int          exp_writes;
        int          exp_starts;
        logic [15:0] exp_class;
        bit          exp_error;
        bit          chk_timeout;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] exp_q[$];

    int          checks;
    int          errors;
    int          cyc;
    int          done_at;
    int          cur_delay;
    logic [15:0] cur_pred;
    int          nwrites;
    int          nstarts;
    int          last_we_cyc;
    int          start_cyc;
    int          res_cyc;
    logic [15:0] cls_seen;
    logic        err_seen;
    logic        busy_seen;
    logic        accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the negedge, then advance past posedge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        accepted = pix_valid && pix_ready;
        if (mem_we) begin
            nwrites++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("mem_write", {6'd0, mem_addr, mem_wdata}, e);
            end
        end
        if (net_start) begin
            nstarts++;
            start_cyc = cyc;
            chk("start_after_last_write", 32'(cyc - last_we_cyc), 32'd1);
            if (cur_delay >= 0) done_at = cyc + cur_delay;
        end
        if (res_valid && res_cyc < 0) begin
            res_cyc   = cyc;
            cls_seen  = res_class;
            err_seen  = res_error;
            busy_seen = busy;
        end
        @(posedge clk);
        #1;
        cyc++;
        net_done       = (cyc == done_at);
        net_prediction = cur_pred;
    endtask

    task automatic send_beat(input int i, input bit last, input bit gaps, input bit expect_wr);
        int n;
        if (gaps && $urandom_range(0, 1) == 1) begin
            pix_valid = 1'b0;
            step();
        end
        pix_valid = 1'b1;
        pix_data  = 16'(i);
        pix_last  = last;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 100);
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: beat %0d not accepted, required pix_ready", i);
        end else if (expect_wr) begin
            exp_q.push_back({6'd0, 10'(i), 16'(i)});
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
        chk({tag, "_ctrl"}, 32'({mem_we, net_start, res_valid, res_error, busy}), 32'd0);
        chk({tag, "_buses"}, {6'd0, mem_addr, mem_wdata}, 32'd0);
        chk({tag, "_res_class"}, 32'(res_class), 32'd0);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int n;
        cur_delay = v.done_delay;
        cur_pred  = v.pred;
        done_at   = -1;
        nwrites   = 0;
        nstarts   = 0;
        res_cyc   = -1;
        start_cyc = -1;
        res_ready = (v.hold == 0);
        for (int i = 0; i < v.nbeats; i++) begin
            send_beat(i, (i == v.last_idx), v.gaps, (i < v.exp_writes));
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        n = 0;
        while (res_cyc < 0 && n < 2000) begin
            step();
            n++;
        end
        if (res_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_result_wait: no res_valid within 2000 cycles", tag);
        end
        chk({tag, "_class"}, 32'(cls_seen), 32'(v.exp_class));
        chk({tag, "_error"}, 32'(err_seen), 32'(v.exp_error));
        chk({tag, "_busy_in_result"}, 32'(busy_seen), 32'd1);
        if (v.chk_timeout) begin
            chk({tag, "_timeout_latency"}, 32'(res_cyc - start_cyc), 32'(TO));
        end
        if (v.hold > 0) begin
            for (int k = 0; k < v.hold; k++) begin
                step();
                chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
                chk({tag, "_hold_class"}, 32'(res_class), 32'(v.exp_class));
                chk({tag, "_hold_error"}, 32'(res_error), 32'(v.exp_error));
                chk({tag, "_hold_pix_ready"}, 32'(pix_ready), 32'd0);
            end
            res_ready = 1'b1;
        end
        n = 0;
        while (res_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_res_valid_cleared"}, 32'(res_valid), 32'd0);
        chk({tag, "_pix_ready_back"}, 32'(pix_ready), 32'd1);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_writes"}, 32'(nwrites), 32'(v.exp_writes));
        chk({tag, "_starts"}, 32'(nstarts), 32'(v.exp_starts));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        done_at = -1;
        cur_delay = -1;
        cur_pred = '0;
        last_we_cyc = -10;
        accepted = 1'b0;
        rst = 1'b1;
        pix_data = '0;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        net_done = 1'b0;
        net_prediction = '0;
        res_ready = 1'b1;

        //              beats last gaps delay pred  hold wr   st  class     err tmo
        tbl[0] = '{NPIX, 783, 1'b0, 50, 16'd7, 0,  784, 1, 16'd7,    1'b0, 1'b0};
        tbl[1] = '{NPIX, 783, 1'b1, 30, 16'd3, 0,  784, 1, 16'd3,    1'b0, 1'b0};
        tbl[2] = '{100,  99,  1'b0, 50, 16'd5, 0,  100, 0, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{790,  789, 1'b0, 50, 16'd5, 0,  784, 0, 16'hFFFF, 1'b1, 1'b0};
        tbl[4] = '{NPIX, 783, 1'b0, -1, 16'd0, 20, 784, 1, 16'hFFFF, 1'b1, 1'b1};
        // done arrives exactly on the final timeout cycle: done must win
        tbl[5] = '{NPIX, 783, 1'b0, TO - 1, 16'd9, 0, 784, 1, 16'd9, 1'b0, 1'b0};

        #2;
        check_idle("reset");
        step();
        step();
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_vector(tbl[v], $sformatf("vec%0d", v));
        end

        // Reset in the middle of a frame
        cur_delay = -1;
        done_at   = -1;
        for (int i = 0; i < 400; i++) begin
            send_beat(i, 1'b0, 1'b0, 1'b1);
        end
        pix_valid = 1'b0;
        step();
        chk("midframe_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        chk("midframe_pending", 32'(exp_q.size()), 32'd0);
        step();
        step();
        rst = 1'b0;
        run_vector(tbl[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
